// File: rtl/vga_pkg.sv
// Shared types and helpers for the VGA box overlay: colour, box records and bound clamping.
package vga_pkg;

    localparam int H_RES   = 640;
    localparam int V_RES   = 480;
    localparam int BOUND_W = 11;

    typedef logic [11:0] color_t;
    typedef logic signed [BOUND_W-1:0] bound_t;

    // Box as written by the host: centre, half-size, colour, enable.
    typedef struct packed {
        logic [9:0] cx;
        logic [8:0] cy;
        logic [7:0] half;
        color_t     color;
        logic       vis;
    } box_t;

    // Box as displayed: inclusive clipped bounds, precomputed at commit.
    typedef struct packed {
        bound_t left;
        bound_t right;
        bound_t top;
        bound_t bottom;
        color_t color;
        logic   vis;
    } live_box_t;

    // Lower bound clipped at 0, so boxes near the left/top edge never wrap.
    function automatic bound_t bound_lo(input int c, input int h);
        int v;
        v = c - h;
        if (v < 0) v = 0;
        return bound_t'(v);
    endfunction

    // Upper bound clipped at lim-1; computed in int so cx+half cannot overflow.
    function automatic bound_t bound_hi(input int c, input int h, input int lim);
        int v;
        v = c + h;
        if (v > lim - 1) v = lim - 1;
        return bound_t'(v);
    endfunction

endpackage

// File: rtl/box_hit_test.sv
// Combinational coverage test of one live box against the current pixel.
module box_hit_test (
    input  vga_pkg::live_box_t box_i,
    input  logic [9:0]         x_i,
    input  logic [8:0]         y_i,
    output logic               hit_o
);

    logic signed [10:0] xs;
    logic signed [10:0] ys;

    // Inclusive rectangle test on signed bounds; invisible boxes never hit.
    always_comb begin
        xs    = $signed({1'b0, x_i});
        ys    = $signed({2'b00, y_i});
        hit_o = box_i.vis &&
                ($signed(box_i.left) <= xs) && (xs <= $signed(box_i.right)) &&
                ($signed(box_i.top) <= ys) && (ys <= $signed(box_i.bottom));
    end

endmodule

// File: rtl/vga_box_compositor.sv
// N-box overlay between timing generator and VGA pins: double-buffered box bank committed at
// frame end, index-priority compositing over the background, syncs delayed to match.
module vga_box_compositor #(
    parameter int N_BOXES = 4,
    parameter int IDX_W   = 2,
    parameter int H_RES   = vga_pkg::H_RES,
    parameter int V_RES   = vga_pkg::V_RES,
    parameter int BG_LAT  = 2
) (
    input  logic             clk_25mHz,
    input  logic             reset,
    input  logic [9:0]       x,
    input  logic [8:0]       y,
    input  logic             active_in,
    input  logic             hSync_in,
    input  logic             vSync_in,
    input  logic             screenEnd,
    input  logic [11:0]      bg_color,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic [9:0]       wr_cx,
    input  logic [8:0]       wr_cy,
    input  logic [7:0]       wr_half,
    input  logic [11:0]      wr_color,
    input  logic             wr_vis,
    input  logic             commit_req,
    output logic             commit_pend,
    output logic [15:0]      frame_count,
    output logic [IDX_W-1:0] hit_idx,
    output logic             hit,
    output logic             hSync,
    output logic             vSync,
    output logic [3:0]       VGA_R,
    output logic [3:0]       VGA_G,
    output logic [3:0]       VGA_B
);
    import vga_pkg::color_t;
    import vga_pkg::box_t;
    import vga_pkg::live_box_t;
    import vga_pkg::bound_lo;
    import vga_pkg::bound_hi;

    box_t       shadow_q [N_BOXES];
    box_t       shadow_d [N_BOXES];
    live_box_t  live_q   [N_BOXES];
    live_box_t  live_d   [N_BOXES];
    logic       se_q, fe, wr_ok;
    logic       commit_pend_q, commit_pend_d;
    logic [15:0] frame_cnt_q, frame_cnt_d;

    logic [N_BOXES-1:0] hits;
    logic [N_BOXES-1:0] hv_q  [BG_LAT];
    logic               act_q [BG_LAT];
    logic               hs_q  [BG_LAT];
    logic               vs_q  [BG_LAT];

    logic [IDX_W-1:0] win_idx;
    logic             win_hit;
    color_t           win_color;

    color_t           rgb_q;
    logic             hit_q, hsync_q, vsync_q;
    logic [IDX_W-1:0] idx_q;

    for (genvar i = 0; i < N_BOXES; i++) begin : g_box
        box_hit_test u_hit (
            .box_i (live_q[i]),
            .x_i   (x),
            .y_i   (y),
            .hit_o (hits[i])
        );
    end

    // Shadow writes, frame-end commit (from pre-write shadow) and frame counting.
    always_comb begin
        fe            = screenEnd & ~se_q;
        wr_ok         = wr_en && (int'(wr_idx) < N_BOXES);
        shadow_d      = shadow_q;
        live_d        = live_q;
        commit_pend_d = commit_pend_q;
        frame_cnt_d   = fe ? frame_cnt_q + 16'd1 : frame_cnt_q;
        if (wr_ok) begin
            shadow_d[wr_idx] = '{cx: wr_cx, cy: wr_cy, half: wr_half,
                                 color: wr_color, vis: wr_vis};
        end
        if (fe && (commit_pend_q || commit_req)) begin
            for (int i = 0; i < N_BOXES; i++) begin
                live_d[i].left   = bound_lo(int'(shadow_q[i].cx), int'(shadow_q[i].half));
                live_d[i].right  = bound_hi(int'(shadow_q[i].cx), int'(shadow_q[i].half), H_RES);
                live_d[i].top    = bound_lo(int'(shadow_q[i].cy), int'(shadow_q[i].half));
                live_d[i].bottom = bound_hi(int'(shadow_q[i].cy), int'(shadow_q[i].half), V_RES);
                live_d[i].color  = shadow_q[i].color;
                live_d[i].vis    = shadow_q[i].vis;
            end
            commit_pend_d = 1'b0;
        end else if (commit_req) begin
            commit_pend_d = 1'b1;
        end
    end

    // Box banks and frame control state.
    always_ff @(posedge clk_25mHz or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < N_BOXES; i++) begin
                shadow_q[i] <= '0;
                live_q[i]   <= '0;
            end
            se_q          <= 1'b0;
            commit_pend_q <= 1'b0;
            frame_cnt_q   <= '0;
        end else begin
            shadow_q      <= shadow_d;
            live_q        <= live_d;
            se_q          <= screenEnd;
            commit_pend_q <= commit_pend_d;
            frame_cnt_q   <= frame_cnt_d;
        end
    end

    // Hit vector and pixel controls delayed to line up with bg_color.
    always_ff @(posedge clk_25mHz or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < BG_LAT; i++) begin
                hv_q[i]  <= '0;
                act_q[i] <= 1'b0;
                hs_q[i]  <= 1'b1;
                vs_q[i]  <= 1'b1;
            end
        end else begin
            hv_q[0]  <= hits;
            act_q[0] <= active_in;
            hs_q[0]  <= hSync_in;
            vs_q[0]  <= vSync_in;
            for (int i = 1; i < BG_LAT; i++) begin
                hv_q[i]  <= hv_q[i-1];
                act_q[i] <= act_q[i-1];
                hs_q[i]  <= hs_q[i-1];
                vs_q[i]  <= vs_q[i-1];
            end
        end
    end

    // Priority mux: later (higher) index overrides, background when nothing hits.
    always_comb begin
        win_idx   = '0;
        win_hit   = 1'b0;
        win_color = bg_color;
        for (int i = 0; i < N_BOXES; i++) begin
            if (hv_q[BG_LAT-1][i]) begin
                win_idx   = IDX_W'(i);
                win_hit   = 1'b1;
                win_color = live_q[i].color;
            end
        end
    end

    // Output stage: colour blanked outside the visible area.
    always_ff @(posedge clk_25mHz or posedge reset) begin
        if (reset) begin
            rgb_q   <= '0;
            hit_q   <= 1'b0;
            idx_q   <= '0;
            hsync_q <= 1'b1;
            vsync_q <= 1'b1;
        end else begin
            rgb_q   <= act_q[BG_LAT-1] ? win_color : '0;
            hit_q   <= win_hit;
            idx_q   <= win_idx;
            hsync_q <= hs_q[BG_LAT-1];
            vsync_q <= vs_q[BG_LAT-1];
        end
    end

    assign commit_pend = commit_pend_q;
    assign frame_count = frame_cnt_q;
    assign hit         = hit_q;
    assign hit_idx     = idx_q;
    assign hSync       = hsync_q;
    assign vSync       = vsync_q;
    assign VGA_R       = rgb_q[11:8];
    assign VGA_G       = rgb_q[7:4];
    assign VGA_B       = rgb_q[3:0];

endmodule

// File: tb/tb_vga_box_compositor.sv
// Directed bench for vga_box_compositor: background path, commit timing, priority, clipping,
// and asynchronous reset.
module tb_vga_box_compositor;

    logic        clk_25mHz = 1'b0;
    logic        reset = 1'b1;
    logic [9:0]  x = '0;
    logic [8:0]  y = '0;
    logic        active_in = 1'b0;
    logic        hSync_in = 1'b1;
    logic        vSync_in = 1'b1;
    logic        screenEnd = 1'b0;
    logic [11:0] bg_color;
    logic        wr_en = 1'b0;
    logic [1:0]  wr_idx = '0;
    logic [9:0]  wr_cx = '0;
    logic [8:0]  wr_cy = '0;
    logic [7:0]  wr_half = '0;
    logic [11:0] wr_color = '0;
    logic        wr_vis = 1'b0;
    logic        commit_req = 1'b0;
    logic        commit_pend;
    logic [15:0] frame_count;
    logic [1:0]  hit_idx;
    logic        hit;
    logic        hSync;
    logic        vSync;
    logic [3:0]  VGA_R;
    logic [3:0]  VGA_G;
    logic [3:0]  VGA_B;

    int n_vec = 0;
    int n_err = 0;

    // Background source: two-cycle-late pattern derived from x, as an image+palette RAM would be.
    logic [9:0] xd1 = '0;
    logic [9:0] xd2 = '0;
    always @(posedge clk_25mHz) begin
        xd1 <= x;
        xd2 <= xd1;
    end
    assign bg_color = {2'b10, xd2};

    always #20 clk_25mHz = ~clk_25mHz;

    vga_box_compositor dut (
        .clk_25mHz   (clk_25mHz),
        .reset       (reset),
        .x           (x),
        .y           (y),
        .active_in   (active_in),
        .hSync_in    (hSync_in),
        .vSync_in    (vSync_in),
        .screenEnd   (screenEnd),
        .bg_color    (bg_color),
        .wr_en       (wr_en),
        .wr_idx      (wr_idx),
        .wr_cx       (wr_cx),
        .wr_cy       (wr_cy),
        .wr_half     (wr_half),
        .wr_color    (wr_color),
        .wr_vis      (wr_vis),
        .commit_req  (commit_req),
        .commit_pend (commit_pend),
        .frame_count (frame_count),
        .hit_idx     (hit_idx),
        .hit         (hit),
        .hSync       (hSync),
        .vSync       (vSync),
        .VGA_R       (VGA_R),
        .VGA_G       (VGA_G),
        .VGA_B       (VGA_B)
    );

    function automatic logic [11:0] bgc(input int px);
        logic [9:0] xv;
        xv = 10'(px);
        return {2'b10, xv};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_px(input string tag, input logic [11:0] rgb, input logic h,
                          input logic [1:0] idx);
        chk({tag, ".rgb"}, {20'd0, VGA_R, VGA_G, VGA_B}, {20'd0, rgb});
        chk({tag, ".hit"}, {31'd0, hit}, {31'd0, h});
        if (h) chk({tag, ".idx"}, {30'd0, hit_idx}, {30'd0, idx});
    endtask

    // One visible pixel, then idle; returns at the negedge after its output edge.
    task automatic probe(input int px, input int py, input logic hs, input logic vs);
        @(negedge clk_25mHz);
        x = 10'(px); y = 9'(py); active_in = 1'b1; hSync_in = hs; vSync_in = vs;
        @(negedge clk_25mHz);
        x = '0; y = '0; active_in = 1'b0; hSync_in = 1'b1; vSync_in = 1'b1;
        @(negedge clk_25mHz);
        @(negedge clk_25mHz);
    endtask

    task automatic wr_box(input int idx, input int cx, input int cy, input int half,
                          input logic [11:0] col, input logic vis);
        @(negedge clk_25mHz);
        wr_en = 1'b1; wr_idx = 2'(idx); wr_cx = 10'(cx); wr_cy = 9'(cy);
        wr_half = 8'(half); wr_color = col; wr_vis = vis;
        @(negedge clk_25mHz);
        wr_en = 1'b0;
    endtask

    task automatic commit();
        @(negedge clk_25mHz);
        commit_req = 1'b1;
        @(negedge clk_25mHz);
        commit_req = 1'b0;
    endtask

    // screenEnd held for two cycles: only its rising edge is a frame end.
    task automatic frame_end(input logic with_commit);
        @(negedge clk_25mHz);
        screenEnd = 1'b1; commit_req = with_commit;
        @(negedge clk_25mHz);
        commit_req = 1'b0;
        @(negedge clk_25mHz);
        screenEnd = 1'b0;
    endtask

    initial begin
        // Reset state
        repeat (2) @(negedge clk_25mHz);
        chk("rst.rgb", {20'd0, VGA_R, VGA_G, VGA_B}, 32'd0);
        chk("rst.hit", {31'd0, hit}, 32'd0);
        chk("rst.hsync", {31'd0, hSync}, 32'd1);
        chk("rst.vsync", {31'd0, vSync}, 32'd1);
        chk("rst.fc", {16'd0, frame_count}, 32'd0);
        chk("rst.pend", {31'd0, commit_pend}, 32'd0);
        reset = 1'b0;

        // Background only, with latency and sync delay checks
        @(negedge clk_25mHz);
        x = 10'd100; y = 9'd100; active_in = 1'b1; hSync_in = 1'b0; vSync_in = 1'b0;
        @(negedge clk_25mHz);
        x = '0; y = '0; active_in = 1'b0; hSync_in = 1'b1; vSync_in = 1'b1;
        @(negedge clk_25mHz);
        chk("lat.early_rgb", {20'd0, VGA_R, VGA_G, VGA_B}, 32'd0);
        chk("lat.early_hs", {31'd0, hSync}, 32'd1);
        @(negedge clk_25mHz);
        chk_px("bg100", bgc(100), 1'b0, 2'd0);
        chk("bg100.hsync", {31'd0, hSync}, 32'd0);
        chk("bg100.vsync", {31'd0, vSync}, 32'd0);

        // Single green box, committed at one frame end
        wr_box(0, 100, 100, 25, 12'h0F0, 1'b1);
        probe(100, 100, 1'b1, 1'b1);
        chk_px("precommit", bgc(100), 1'b0, 2'd0);
        commit();
        chk("pend.set", {31'd0, commit_pend}, 32'd1);
        frame_end(1'b0);
        chk("pend.clr", {31'd0, commit_pend}, 32'd0);
        chk("fc1", {16'd0, frame_count}, 32'd1);
        probe(75, 75, 1'b1, 1'b1);    chk_px("b0.tl", 12'h0F0, 1'b1, 2'd0);
        probe(125, 125, 1'b1, 1'b1);  chk_px("b0.br", 12'h0F0, 1'b1, 2'd0);
        probe(74, 100, 1'b1, 1'b1);   chk_px("b0.x74", bgc(74), 1'b0, 2'd0);
        probe(126, 100, 1'b1, 1'b1);  chk_px("b0.x126", bgc(126), 1'b0, 2'd0);
        probe(100, 74, 1'b1, 1'b1);   chk_px("b0.y74", bgc(100), 1'b0, 2'd0);

        // Overlap priority: box1 over box0
        wr_box(0, 100, 100, 25, 12'h00F, 1'b1);
        wr_box(1, 110, 100, 25, 12'h0F0, 1'b1);
        commit();
        frame_end(1'b0);
        probe(110, 100, 1'b1, 1'b1);  chk_px("pri.x110", 12'h0F0, 1'b1, 2'd1);
        probe(80, 100, 1'b1, 1'b1);   chk_px("pri.x80", 12'h00F, 1'b1, 2'd0);
        probe(130, 100, 1'b1, 1'b1);  chk_px("pri.x130", 12'h0F0, 1'b1, 2'd1);

        // Left-edge clipping, no wrap to the right side
        wr_box(2, 10, 100, 25, 12'hF00, 1'b1);
        commit();
        frame_end(1'b0);
        probe(0, 100, 1'b1, 1'b1);    chk_px("clip.x0", 12'hF00, 1'b1, 2'd2);
        probe(35, 100, 1'b1, 1'b1);   chk_px("clip.x35", 12'hF00, 1'b1, 2'd2);
        probe(36, 100, 1'b1, 1'b1);   chk_px("clip.x36", bgc(36), 1'b0, 2'd0);
        probe(625, 100, 1'b1, 1'b1);  chk_px("clip.x625", bgc(625), 1'b0, 2'd0);
        probe(639, 100, 1'b1, 1'b1);  chk_px("clip.x639", bgc(639), 1'b0, 2'd0);

        // Write without commit leaves display alone; commit_req on the frame-end cycle applies
        wr_box(3, 300, 200, 10, 12'hFFF, 1'b1);
        frame_end(1'b0);
        probe(300, 200, 1'b1, 1'b1);  chk_px("nocommit", bgc(300), 1'b0, 2'd0);
        chk("nocommit.pend", {31'd0, commit_pend}, 32'd0);
        frame_end(1'b1);
        chk("samecyc.pend", {31'd0, commit_pend}, 32'd0);
        chk("fc5", {16'd0, frame_count}, 32'd5);
        probe(300, 200, 1'b1, 1'b1);  chk_px("b3.ctr", 12'hFFF, 1'b1, 2'd3);
        probe(290, 190, 1'b1, 1'b1);  chk_px("b3.tl", 12'hFFF, 1'b1, 2'd3);
        probe(311, 200, 1'b1, 1'b1);  chk_px("b3.x311", bgc(311), 1'b0, 2'd0);

        // Asynchronous reset in the middle of a visible run
        @(negedge clk_25mHz);
        x = 10'd300; y = 9'd200; active_in = 1'b1;
        repeat (3) @(negedge clk_25mHz);
        chk_px("pre_rst", 12'hFFF, 1'b1, 2'd3);
        #5 reset = 1'b1;
        #1;
        chk("mrst.rgb", {20'd0, VGA_R, VGA_G, VGA_B}, 32'd0);
        chk("mrst.hit", {31'd0, hit}, 32'd0);
        chk("mrst.fc", {16'd0, frame_count}, 32'd0);
        @(negedge clk_25mHz);
        reset = 1'b0;
        repeat (3) @(negedge clk_25mHz);
        chk_px("post_rst", bgc(300), 1'b0, 2'd0);
        active_in = 1'b0;
        frame_end(1'b0);
        chk("post_rst.fc", {16'd0, frame_count}, 32'd1);
        probe(300, 200, 1'b1, 1'b1);  chk_px("post_rst.fe", bgc(300), 1'b0, 2'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
